// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: stalls decode on RAW/WAW/divider hazards and
// steers the execute-stage operand bypass muxes (regfile / EXE / WB).
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  flush_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_we_i,
   input  logic [1:0]            id_unit_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_dst_i,
   input  logic                  div_done_i,
   output logic                  issue_o,
   output logic                  stall_o,
   output logic [1:0]            rs1_sel_o,
   output logic [1:0]            rs2_sel_o,
   output logic                  div_busy_o,
   output logic [NUM_REGS-1:0]   pending_o
);

   localparam logic [1:0] UNIT_ALU = 2'b00;
   localparam logic [1:0] UNIT_DIV = 2'b10;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EXE = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   localparam logic [REG_ADDR_W-1:0] X0 = '0;

   logic [NUM_REGS-1:0]   pending_q, pending_d;
   logic                  div_busy_q, div_busy_d;
   logic                  exe_valid_q, exe_valid_d;
   logic [REG_ADDR_W-1:0] exe_rd_q, exe_rd_d;

   logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
   logic haz_rs1, haz_rs2, haz_waw, haz_div;
   logic any_haz, issue;

   // A writeback landing this cycle is forwarded, so it resolves the hazard.
   assign wb_hit_rs1 = wb_we_i && (wb_dst_i == id_rs1_i);
   assign wb_hit_rs2 = wb_we_i && (wb_dst_i == id_rs2_i);
   assign wb_hit_rd  = wb_we_i && (wb_dst_i == id_rd_i);

   assign haz_rs1 = id_use_rs1_i && (id_rs1_i != X0) && pending_q[id_rs1_i] && !wb_hit_rs1;
   assign haz_rs2 = id_use_rs2_i && (id_rs2_i != X0) && pending_q[id_rs2_i] && !wb_hit_rs2;
   assign haz_waw = id_we_i && (id_rd_i != X0) && pending_q[id_rd_i] && !wb_hit_rd;
   assign haz_div = (id_unit_i == UNIT_DIV) && div_busy_q && !div_done_i;

   assign any_haz = haz_rs1 || haz_rs2 || haz_waw || haz_div;
   assign stall_o = id_valid_i && !flush_i && any_haz;
   assign issue   = id_valid_i && !flush_i && !any_haz;
   assign issue_o = issue;

   always_comb begin
      rs1_sel_o = SEL_RF;
      if (exe_valid_q && (exe_rd_q == id_rs1_i) && (id_rs1_i != X0))
         rs1_sel_o = SEL_EXE;
      else if (wb_hit_rs1 && (id_rs1_i != X0))
         rs1_sel_o = SEL_WB;
   end

   always_comb begin
      rs2_sel_o = SEL_RF;
      if (exe_valid_q && (exe_rd_q == id_rs2_i) && (id_rs2_i != X0))
         rs2_sel_o = SEL_EXE;
      else if (wb_hit_rs2 && (id_rs2_i != X0))
         rs2_sel_o = SEL_WB;
   end

   // Set after clear so a same-cycle re-issue to a retiring register stays pending.
   always_comb begin
      pending_d = pending_q;
      if (wb_we_i && (wb_dst_i != X0))
         pending_d[wb_dst_i] = 1'b0;
      if (issue && (id_unit_i != UNIT_ALU) && id_we_i && (id_rd_i != X0))
         pending_d[id_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      div_busy_d = div_busy_q;
      if (issue && (id_unit_i == UNIT_DIV))
         div_busy_d = 1'b1;
      else if (div_done_i)
         div_busy_d = 1'b0;
   end

   always_comb begin
      exe_valid_d = 1'b0;
      exe_rd_d    = exe_rd_q;
      if (issue) begin
         exe_valid_d = (id_unit_i == UNIT_ALU) && id_we_i && (id_rd_i != X0);
         exe_rd_d    = id_rd_i;
      end
      if (flush_i)
         exe_valid_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pending_q   <= '0;
         div_busy_q  <= 1'b0;
         exe_valid_q <= 1'b0;
         exe_rd_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         div_busy_q  <= div_busy_d;
         exe_valid_q <= exe_valid_d;
         exe_rd_q    <= exe_rd_d;
      end
   end

   assign div_busy_o = div_busy_q;
   assign pending_o  = pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed expectations for
// forwarding, load/div/mul hazards, x0 handling, flush and async reset.
module tb_hazard_scoreboard;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        flush_i;
   logic        id_valid_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_use_rs1_i, id_use_rs2_i, id_we_i;
   logic [1:0]  id_unit_i;
   logic        wb_we_i;
   logic [4:0]  wb_dst_i;
   logic        div_done_i;
   logic        issue_o, stall_o, div_busy_o;
   logic [1:0]  rs1_sel_o, rs2_sel_o;
   logic [31:0] pending_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] ALU = 2'b00, MUL = 2'b01, DIV = 2'b10, MEM = 2'b11;

   hazard_scoreboard #(.REG_ADDR_W(5), .NUM_REGS(32)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_unit_i(id_unit_i),
      .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i), .div_done_i(div_done_i),
      .issue_o(issue_o), .stall_o(stall_o),
      .rs1_sel_o(rs1_sel_o), .rs2_sel_o(rs2_sel_o),
      .div_busy_o(div_busy_o), .pending_o(pending_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush_i = 0; id_valid_i = 0;
      id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
      id_rd_i = 0; id_we_i = 0; id_unit_i = ALU;
      wb_we_i = 0; wb_dst_i = 0; div_done_i = 0;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic [1:0] unit);
      id_valid_i = 1; id_rs1_i = rs1; id_use_rs1_i = u1; id_rs2_i = rs2;
      id_use_rs2_i = u2; id_rd_i = rd; id_we_i = we; id_unit_i = unit;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] dst, input logic done);
      wb_we_i = we; wb_dst_i = dst; div_done_i = done;
   endtask

   // Inputs change 1 time unit after the rising edge, checks 1 unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rstn_i = 0;
      #1;
      chk("rst_pending", pending_o, 32'h0);
      chk("rst_div_busy", {31'b0, div_busy_o}, 32'h0);
      chk("rst_issue", {31'b0, issue_o}, 32'h0);
      chk("rst_stall", {31'b0, stall_o}, 32'h0);
      chk("rst_sel", {28'b0, rs1_sel_o, rs2_sel_o}, 32'h0);
      #12 rstn_i = 1;
      tick();

      // ALU x5 = x1 op x2, then back-to-back reader of x5 forwards from EXE
      set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, ALU); #1;
      chk("alu_issue", {31'b0, issue_o}, 32'h1);
      chk("alu_sel_rf", {28'b0, rs1_sel_o, rs2_sel_o}, 32'h0);
      tick();
      set_id(5'd5, 1, 5'd5, 1, 5'd6, 1, ALU); #1;
      chk("fwd_issue", {31'b0, issue_o}, 32'h1);
      chk("fwd_stall", {31'b0, stall_o}, 32'h0);
      chk("fwd_rs1_sel", {30'b0, rs1_sel_o}, 32'h1);
      chk("fwd_rs2_sel", {30'b0, rs2_sel_o}, 32'h1);
      tick();
      tick();

      // MEM load x7, consumer stalls three cycles, WB on cycle 4 releases it
      set_id(5'd0, 0, 5'd0, 0, 5'd7, 1, MEM); #1;
      chk("ld_issue", {31'b0, issue_o}, 32'h1);
      tick();
      chk("ld_pending", pending_o, 32'h0000_0080);
      for (int c = 1; c <= 3; c++) begin
         set_id(5'd7, 1, 5'd0, 0, 5'd8, 1, ALU); #1;
         chk($sformatf("ld_stall_c%0d", c), {30'b0, stall_o, issue_o}, 32'h2);
         tick();
      end
      set_id(5'd7, 1, 5'd0, 0, 5'd8, 1, ALU);
      set_wb(1, 5'd7, 0); #1;
      chk("ld_wb_stall", {30'b0, stall_o, issue_o}, 32'h1);
      chk("ld_wb_sel", {30'b0, rs1_sel_o}, 32'h2);
      tick();
      chk("ld_cleared", pending_o, 32'h0);

      // DIV x3, second DIV blocked until div_done, busy stays set across it
      set_id(5'd0, 0, 5'd0, 0, 5'd3, 1, DIV); #1;
      chk("div1_issue", {31'b0, issue_o}, 32'h1);
      tick();
      chk("div1_busy", {31'b0, div_busy_o}, 32'h1);
      chk("div1_pending", pending_o, 32'h0000_0008);
      set_id(5'd1, 1, 5'd0, 0, 5'd10, 1, DIV); #1;
      chk("div2_struct_stall", {30'b0, stall_o, issue_o}, 32'h2);
      tick();
      set_id(5'd1, 1, 5'd0, 0, 5'd10, 1, DIV); #1;
      chk("div2_still_stall", {30'b0, stall_o, issue_o}, 32'h2);
      set_wb(1, 5'd3, 1); #1;
      chk("div2_issue_on_done", {30'b0, stall_o, issue_o}, 32'h1);
      tick();
      chk("div2_busy_kept", {31'b0, div_busy_o}, 32'h1);
      chk("div2_pending", pending_o, 32'h0000_0400);
      set_wb(1, 5'd10, 1);
      tick();
      chk("div_idle_busy", {31'b0, div_busy_o}, 32'h0);
      chk("div_idle_pending", pending_o, 32'h0);

      // MUL x9: WAW stall, then WB x9 plus new MUL x9 in one cycle keeps bit set
      set_id(5'd0, 0, 5'd0, 0, 5'd9, 1, MUL); #1;
      chk("mul_issue", {31'b0, issue_o}, 32'h1);
      tick();
      set_id(5'd0, 0, 5'd0, 0, 5'd9, 1, ALU); #1;
      chk("waw_stall", {30'b0, stall_o, issue_o}, 32'h2);
      tick();
      set_id(5'd0, 0, 5'd0, 0, 5'd9, 1, MUL);
      set_wb(1, 5'd9, 0); #1;
      chk("mul_reissue", {30'b0, stall_o, issue_o}, 32'h1);
      tick();
      chk("mul_set_wins", pending_o, 32'h0000_0200);
      set_wb(1, 5'd9, 0);
      tick();
      chk("mul_cleared", pending_o, 32'h0);

      // x0 is never tracked or forwarded
      set_id(5'd0, 1, 5'd0, 1, 5'd0, 1, MEM);
      set_wb(1, 5'd0, 0); #1;
      chk("x0_no_stall", {30'b0, stall_o, issue_o}, 32'h1);
      chk("x0_sel", {28'b0, rs1_sel_o, rs2_sel_o}, 32'h0);
      tick();
      chk("x0_pending", pending_o, 32'h0);

      // MEM x12 pending, ALU x4 issued, flush kills EXE forwarding only
      set_id(5'd0, 0, 5'd0, 0, 5'd12, 1, MEM);
      tick();
      set_id(5'd0, 0, 5'd0, 0, 5'd4, 1, ALU); #1;
      chk("fl_alu_issue", {31'b0, issue_o}, 32'h1);
      tick();
      set_id(5'd12, 1, 5'd0, 0, 5'd13, 1, ALU);
      flush_i = 1; #1;
      chk("fl_masked", {30'b0, stall_o, issue_o}, 32'h0);
      tick();
      set_id(5'd4, 1, 5'd0, 0, 5'd14, 1, ALU); #1;
      chk("fl_rs1_sel", {30'b0, rs1_sel_o}, 32'h0);
      chk("fl_reader_issue", {31'b0, issue_o}, 32'h1);
      chk("fl_pending_kept", pending_o, 32'h0000_1000);
      tick();

      // Async reset mid-operation clears state without a clock edge
      set_id(5'd0, 0, 5'd0, 0, 5'd9, 1, DIV);
      tick();
      chk("pre_rst_pending", pending_o, 32'h0000_1200);
      #2 rstn_i = 0;
      #1;
      chk("async_rst_pending", pending_o, 32'h0);
      chk("async_rst_busy", {31'b0, div_busy_o}, 32'h0);
      #3 rstn_i = 1;
      tick();
      set_wb(1, 5'd12, 1);
      tick();
      chk("late_wb_harmless", {pending_o[31:1], div_busy_o}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Issue-stage controller that sequences the execute-stage operand bypass muxes and stalls decode on data and structural hazards. It keeps a per-register pending scoreboard for long-latency ops (MUL, DIV, MEM) and tracks the single-cycle ALU op in EXE. From these it drives the select of each source-operand mux (regfile / EXE result / WB result). It sits between decode and the execute-stage bypass muxes and consumes the writeback port.

Parameters:
REG_ADDR_W, 5, architectural register index width
NUM_REGS, 32, number of tracked registers (2**REG_ADDR_W); x0 is never tracked

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  asynchronous active-low reset
flush_i  input  1  pipeline flush (kill ID and EXE tracking)
id_valid_i  input  1  decode holds a valid instruction
id_rs1_i  input  5  source 1 index
id_rs2_i  input  5  source 2 index
id_use_rs1_i  input  1  instruction reads rs1
id_use_rs2_i  input  1  instruction reads rs2
id_rd_i  input  5  destination index
id_we_i  input  1  instruction writes rd
id_unit_i  input  2  00 ALU (1 cycle), 01 MUL, 10 DIV, 11 MEM
wb_we_i  input  1  writeback valid
wb_dst_i  input  5  writeback destination
div_done_i  input  1  divider result delivered (one-cycle pulse)
issue_o  output  1  instruction leaves decode this cycle
stall_o  output  1  hold decode
rs1_sel_o  output  2  00 regfile, 01 EXE result, 10 WB result
rs2_sel_o  output  2  same encoding for rs2
div_busy_o  output  1  divider occupied
pending_o  output  32  scoreboard bits (debug); bit 0 always 0

Behaviour:
- Reset (rstn_i low, async): pending all 0, div_busy 0, exe_valid 0, exe_rd 0. With id_valid_i low, combinational outputs read issue_o 0, stall_o 0, sel 00.
- Source hazard for rsN: id_use_rsN_i & rsN!=0 & pending[rsN] & ~(wb_we_i & wb_dst_i==rsN). A same-cycle WB is bypassed and does not stall.
- WAW hazard: id_we_i & id_rd_i!=0 & pending[id_rd_i] & ~(wb_we_i & wb_dst_i==id_rd_i).
- Structural hazard: id_unit_i==DIV & div_busy & ~div_done_i.
- stall_o = id_valid_i & ~flush_i & (any hazard). issue_o = id_valid_i & ~flush_i & ~stall_o.
- Select for rsN, evaluated in priority order:
  - 01 if exe_valid & exe_rd==rsN & rsN!=0;
  - else 10 if wb_we_i & wb_dst_i==rsN & rsN!=0;
  - else 00.
  - Selects are driven even when stalled, and are don't-care when issue_o is 0.
- EXE tracking register, updated each clock:
  - On issue: exe_valid <= (id_unit_i==ALU) & id_we_i & id_rd_i!=0, and exe_rd <= id_rd_i.
  - Otherwise (bubble): exe_valid <= 0.
  - flush_i forces exe_valid <= 0.
- Pending update per clock:
  - Clear bit wb_dst_i when wb_we_i & wb_dst_i!=0.
  - Then set bit id_rd_i on issue of a non-ALU op with id_we_i & id_rd_i!=0.
  - If both address the same register in one cycle, the set wins.
  - flush_i does not clear pending bits. Already-issued long-latency ops still write back.
- div_busy: set on issue of a DIV op, cleared by div_done_i. If both occur in the same cycle, it stays set (back-to-back DIV). flush_i does not clear it.
- Latency: the pending bit is visible to decode on the cycle after issue. Hazard checks are zero-latency combinational on ID inputs.
- Reset mid-operation clears all state immediately; outstanding writebacks arriving later only attempt to clear bits that are already clear (harmless).

Test Plan:
- Reset then ALU x5=... issue, next cycle ALU reads x5 -> issue_o 1, rs1_sel_o 01, stall_o 0.
- MEM load to x7 issues at cycle 0; consumer of x7 at cycles 1-3 -> stall_o 1. At cycle 4 assert wb_we_i=1, wb_dst_i=7 -> stall_o 0, rs1_sel_o 10. At cycle 5 pending_o[7]=0.
- DIV to x3 issues; second DIV presented -> stall_o 1, div_busy_o 1. Pulse div_done_i -> second DIV issues the same cycle, div_busy_o stays 1.
- MUL to x9 pending; ALU writing x9 presented -> WAW stall. WB x9 and a new MUL issue to x9 in the same cycle -> pending_o[9]=1 next cycle.
- Instruction with rs1=0, rd=0 and wb_we_i=1, wb_dst_i=0 -> no stall, rs1_sel_o 00, pending_o=0.
- ALU x4 issued, then flush_i=1 -> issue_o 0. Next cycle a reader of x4 sees rs1_sel_o 00. A MEM pending bit set before the flush remains 1.
